// File: rtl/melody_sequencer.sv
// ============================================================================
// Module   : melody_sequencer
// Function : Note-table sequencer feeding half-period and gate to a tone generator.
//            Optional articulation gap enabled by defining SEQ_ARTIC_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module melody_sequencer #(
  parameter int TICK_DIV = 6_250_000,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int HALF_W   = 21,
  parameter int DUR_W    = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_EN,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [HALF_W-1:0] iWR_HALF,
  input  logic [DUR_W-1:0]  iWR_DUR,
  input  logic              iSTART,
  input  logic              iSTOP,
  input  logic              iLOOP,
  output logic [HALF_W-1:0] oHALF,
  output logic              oGATE,
  output logic              oNOTE_STB,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [ADDR_W-1:0] oIDX
);

  localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0]   c_LAST_IDX  = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_PLAY = 2'd2;

  logic [HALF_W-1:0]   r_halfMem [DEPTH];
  logic [DUR_W-1:0]    r_durMem  [DEPTH];

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [c_TICK_W-1:0] r_tick;
  logic [DUR_W-1:0]    r_durCnt;
  logic                r_endOfTable;
  logic [HALF_W-1:0]   r_half;
  logic                r_gate;
  logic                r_noteStb;
  logic                r_busy;
  logic                r_done;

  logic [HALF_W-1:0]   w_rdHalf;
  logic [DUR_W-1:0]    w_rdDur;
  logic                w_isEnd;
  logic                w_artGap;

  // Table is plain storage: writable in any state, never cleared by reset.
  always_ff @(posedge iCLK) begin
    if (iWR_EN) begin
      r_halfMem[iWR_ADDR] <= iWR_HALF;
      r_durMem[iWR_ADDR]  <= iWR_DUR;
    end
  end

  assign w_rdHalf = r_halfMem[r_idx];
  assign w_rdDur  = r_durMem[r_idx];
  // Running off the last entry behaves exactly like an explicit end marker.
  assign w_isEnd  = r_endOfTable || (w_rdDur == '0);

`ifdef SEQ_ARTIC_EN
  logic r_gapOk;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_gapOk <= 1'b0;
    end else if (r_state == c_LOAD) begin
      r_gapOk <= (w_rdDur > DUR_W'(1));
    end
  end

  // Gate drops for the final duration unit of multi-unit notes.
  assign w_artGap = r_gapOk && (r_durCnt == DUR_W'(2));
`else
  assign w_artGap = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= c_IDLE;
      r_idx        <= '0;
      r_tick       <= '0;
      r_durCnt     <= '0;
      r_endOfTable <= 1'b0;
      r_half       <= '0;
      r_gate       <= 1'b0;
      r_noteStb    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_noteStb <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (iSTART) begin
            r_state      <= c_LOAD;
            r_idx        <= '0;
            r_endOfTable <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        c_LOAD: begin
          if (iSTOP) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_tick       <= '0;
            r_durCnt     <= '0;
            r_endOfTable <= 1'b0;
            r_half       <= '0;
            r_gate       <= 1'b0;
            r_busy       <= 1'b0;
          end else if (w_isEnd) begin
            if (iLOOP && ((r_idx != '0) || r_endOfTable)) begin
              r_idx        <= '0;
              r_endOfTable <= 1'b0;
            end else begin
              r_state      <= c_IDLE;
              r_idx        <= '0;
              r_endOfTable <= 1'b0;
              r_half       <= '0;
              r_gate       <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end
          end else begin
            r_state   <= c_PLAY;
            r_half    <= w_rdHalf;
            r_gate    <= (w_rdHalf != '0);
            r_durCnt  <= w_rdDur;
            r_tick    <= '0;
            r_noteStb <= 1'b1;
          end
        end

        c_PLAY: begin
          if (iSTOP) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_tick       <= '0;
            r_durCnt     <= '0;
            r_endOfTable <= 1'b0;
            r_half       <= '0;
            r_gate       <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_tick == c_TICK_LAST) begin
            r_tick   <= '0;
            r_durCnt <= r_durCnt - 1'b1;
            if (w_artGap) begin
              r_gate <= 1'b0;
            end
            if (r_durCnt == DUR_W'(1)) begin
              r_state <= c_LOAD;
              if (r_idx == c_LAST_IDX) begin
                r_endOfTable <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oHALF     = r_half;
  assign oGATE     = r_gate;
  assign oNOTE_STB = r_noteStb;
  assign oBUSY     = r_busy;
  assign oDONE     = r_done;
  assign oIDX      = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
// ============================================================================
// Module   : tb_melody_sequencer
// Function : Self-checking bench for melody_sequencer against a note-schedule model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_melody_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int HALF_W   = 21;
  localparam int DUR_W    = 4;

  typedef struct {
    logic [HALF_W-1:0] half;
    logic              gate;
    logic              stb;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] idx;
    bit                chkIdx;
  } expRec_t;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic              iWR_EN;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [HALF_W-1:0] iWR_HALF;
  logic [DUR_W-1:0]  iWR_DUR;
  logic              iSTART;
  logic              iSTOP;
  logic              iLOOP;
  logic [HALF_W-1:0] oHALF;
  logic              oGATE;
  logic              oNOTE_STB;
  logic              oBUSY;
  logic              oDONE;
  logic [ADDR_W-1:0] oIDX;

  logic [HALF_W-1:0] tHalf [DEPTH];
  logic [DUR_W-1:0]  tDur  [DEPTH];

  int nAsserts = 0;
  int nFail    = 0;

  melody_sequencer #(
    .TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALF_W(HALF_W), .DUR_W(DUR_W)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR),
    .iWR_HALF(iWR_HALF), .iWR_DUR(iWR_DUR), .iSTART(iSTART), .iSTOP(iSTOP),
    .iLOOP(iLOOP), .oHALF(oHALF), .oGATE(oGATE), .oNOTE_STB(oNOTE_STB),
    .oBUSY(oBUSY), .oDONE(oDONE), .oIDX(oIDX)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic expRec_t mk(input logic [HALF_W-1:0] half, input logic gate,
                                 input logic stb, input logic busy, input logic done,
                                 input int idx, input bit chkIdx);
    expRec_t r;
    r.half   = half;
    r.gate   = gate;
    r.stb    = stb;
    r.busy   = busy;
    r.done   = done;
    r.idx    = ADDR_W'((idx >= DEPTH) ? DEPTH - 1 : idx);
    r.chkIdx = chkIdx;
    return r;
  endfunction

  // Expected outputs for every cycle after the start pulse, derived by
  // walking the note list: one load cycle, then dur*TICK_DIV sounding cycles.
  function automatic void buildSchedule(input bit loopEn, input int cap, output expRec_t q[$]);
    logic [HALF_W-1:0] prevHalf = '0;
    logic              prevGate = 1'b0;
    logic              g = 1'b0;
    int                idx = 0;
    q = {};
    while (q.size() < cap) begin
      q.push_back(mk(prevHalf, prevGate, 1'b0, 1'b1, 1'b0, idx, 1'b0));
      if (idx >= DEPTH || tDur[idx] == '0) begin
        if (loopEn && idx != 0) begin
          idx = 0;
          continue;
        end
        q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0));
        q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        break;
      end
      for (int k = 0; k < int'(tDur[idx]) * TICK_DIV; k++) begin
        g = (tHalf[idx] != '0);
`ifdef SEQ_ARTIC_EN
        if (tDur[idx] >= 2 && k >= (int'(tDur[idx]) - 1) * TICK_DIV) g = 1'b0;
`endif
        q.push_back(mk(tHalf[idx], g, (k == 0), 1'b1, 1'b0, idx, (k == 0)));
      end
      prevHalf = tHalf[idx];
      prevGate = g;
      idx++;
    end
  endfunction

  task automatic checkRec(input string name, input int c, input expRec_t r);
    chk($sformatf("%s.c%0d.half", name, c), 32'(oHALF), 32'(r.half));
    chk($sformatf("%s.c%0d.gate", name, c), 32'(oGATE), 32'(r.gate));
    chk($sformatf("%s.c%0d.stb", name, c), 32'(oNOTE_STB), 32'(r.stb));
    chk($sformatf("%s.c%0d.busy", name, c), 32'(oBUSY), 32'(r.busy));
    chk($sformatf("%s.c%0d.done", name, c), 32'(oDONE), 32'(r.done));
    if (r.chkIdx) chk($sformatf("%s.c%0d.idx", name, c), 32'(oIDX), 32'(r.idx));
  endtask

  task automatic checkIdle(input string name);
    chk($sformatf("%s.half", name), 32'(oHALF), 32'd0);
    chk($sformatf("%s.gate", name), 32'(oGATE), 32'd0);
    chk($sformatf("%s.stb", name), 32'(oNOTE_STB), 32'd0);
    chk($sformatf("%s.busy", name), 32'(oBUSY), 32'd0);
    chk($sformatf("%s.done", name), 32'(oDONE), 32'd0);
    chk($sformatf("%s.idx", name), 32'(oIDX), 32'd0);
  endtask

  task automatic writeAll();
    for (int i = 0; i < DEPTH; i++) begin
      iWR_EN   = 1'b1;
      iWR_ADDR = ADDR_W'(i);
      iWR_HALF = tHalf[i];
      iWR_DUR  = tDur[i];
      @(posedge iCLK); #1;
    end
    iWR_EN = 1'b0;
  endtask

  // Start playback, compare each cycle, optionally abort by stop or reset.
  task automatic runSeq(input string name, input bit loopEn, input int cap,
                        input int stopAt, input int rstAt);
    expRec_t q[$];
    buildSchedule(loopEn, cap, q);
    iLOOP  = loopEn;
    iSTART = 1'b1;
    iSTOP  = 1'($urandom_range(0, 1));
    for (int c = 0; c < q.size(); c++) begin
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      iSTOP  = 1'b0;
      checkRec(name, c, q[c]);
      if (c == rstAt) begin
        iRST = 1'b1;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        checkIdle($sformatf("%s.rst", name));
        break;
      end
      if (c == stopAt || (c == q.size() - 1 && q[c].busy)) begin
        iSTOP = 1'b1;
        @(posedge iCLK); #1;
        iSTOP = 1'b0;
        checkIdle($sformatf("%s.stop", name));
        break;
      end
      if (q[c].busy && $urandom_range(0, 7) == 0) iSTART = 1'b1;
    end
    iSTART = 1'b0;
    iLOOP  = 1'b0;
    @(posedge iCLK); #1;
  endtask

  initial begin
    iRST = 1'b1; iWR_EN = 1'b0; iWR_ADDR = '0; iWR_HALF = '0; iWR_DUR = '0;
    iSTART = 1'b0; iSTOP = 1'b0; iLOOP = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tHalf[i] = HALF_W'($urandom_range(1, 1000));
      tDur[i]  = DUR_W'($urandom_range(1, 3));
    end
    repeat (3) @(posedge iCLK);
    #1;
    checkIdle("reset");
    iRST = 1'b0;

    tHalf[0] = 21'd10; tDur[0] = 4'd2;
    tHalf[1] = 21'd0;  tDur[1] = 4'd1;
    tDur[2]  = 4'd0;
    writeAll();
    runSeq("t1_basic", 1'b0, 200, -1, -1);
    runSeq("t2_loop", 1'b1, 45, -1, -1);
    runSeq("t3_stop", 1'b0, 200, 4, -1);
    runSeq("t3_replay", 1'b0, 200, -1, -1);

    tDur[0] = 4'd0;
    writeAll();
    runSeq("t4_marker0", 1'b1, 200, -1, -1);

    for (int i = 0; i < DEPTH; i++) begin
      tHalf[i] = HALF_W'(i + 1);
      tDur[i]  = 4'd1;
    end
    writeAll();
    runSeq("t5_full", 1'b0, 200, -1, -1);
    runSeq("t5_fullloop", 1'b1, 120, -1, -1);

    tHalf[0] = 21'd7; tDur[0] = 4'd3;
    tDur[1]  = 4'd0;
    writeAll();
    runSeq("t6_note", 1'b0, 200, -1, -1);
    runSeq("t6_rst", 1'b0, 200, -1, 6);

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tHalf[i] = ($urandom_range(0, 3) == 0) ? '0 : HALF_W'($urandom_range(1, 2097151));
        tDur[i]  = ($urandom_range(0, 7) == 0) ? '0 : DUR_W'($urandom_range(1, 3));
      end
      writeAll();
      runSeq($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)), 300,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1,
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 60)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the square-wave tone generator.
- Holds a small writable note table. Each entry is a half-period in clock cycles plus a duration in time units.
- On start, steps through the table and presents the current half-period and a gate to the tone generator.
- Supports stop, loop and end-of-melody markers, replacing the hard-wired state/frequency tables.

Parameters:
- TICK_DIV, 6_250_000: clock cycles per duration unit (tick).
- DEPTH, 16: number of note-table entries.
- ADDR_W, 4: table index width; must satisfy 2**ADDR_W == DEPTH.
- HALF_W, 21: half-period field width.
- DUR_W, 4: duration field width.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iWR_EN  in  1  write note entry this cycle.
- iWR_ADDR  in  ADDR_W  entry index to write.
- iWR_HALF  in  HALF_W  half-period in iCLK cycles; 0 = rest.
- iWR_DUR  in  DUR_W  duration in ticks; 0 = end-of-melody marker.
- iSTART  in  1  start playback from entry 0 (sampled in IDLE only).
- iSTOP  in  1  abort playback.
- iLOOP  in  1  level; at end of melody, restart from entry 0.
- oHALF  out  HALF_W  half-period to tone generator.
- oGATE  out  1  sound enable to tone generator.
- oNOTE_STB  out  1  one-cycle pulse on first PLAY cycle of each note.
- oBUSY  out  1  high when not IDLE.
- oDONE  out  1  one-cycle pulse on natural end of melody.
- oIDX  out  ADDR_W  index of entry being played.

Behaviour:
- Reset: state IDLE. oHALF=0, oGATE=0, oNOTE_STB=0, oBUSY=0, oDONE=0, oIDX=0. Tick and duration counters are 0. Table contents are not reset.
- Table writes: accepted in any state, one per cycle. Entry fields are latched only in LOAD, so rewriting the entry being played affects only its next LOAD.
- States: IDLE, LOAD, PLAY. All outputs are registered.
- IDLE:
  - iSTART=1 -> LOAD, idx=0.
  - iSTOP ignored.
- LOAD (one cycle): reads entry[idx]; oHALF/oGATE hold their previous values.
  - If dur==0 (end marker):
    - iLOOP=1 and idx!=0 -> idx=0, stay in LOAD.
    - Otherwise -> IDLE; oDONE=1 next cycle; oHALF=0; oGATE=0.
  - Else -> PLAY:
    - oHALF=half, oGATE=(half!=0), dur_cnt=dur, tick_cnt=0.
    - oNOTE_STB=1 for the first PLAY cycle.
- PLAY:
  - tick_cnt counts 0..TICK_DIV-1 and wraps; on each wrap, dur_cnt decrements.
  - Wrap with dur_cnt==1 -> LOAD with idx+1.
  - Each note therefore occupies dur*TICK_DIV PLAY cycles plus one LOAD cycle.
- End of table: leaving PLAY at idx==DEPTH-1 is treated as an end marker (iLOOP decides), with no read of entry 0 as a continuation.
- iSTOP in LOAD or PLAY:
  - Next state IDLE; oHALF=0, oGATE=0, oIDX=0; no oDONE.
  - iSTOP has priority over tick, duration and end events.
- iSTART while busy is ignored.
- iSTART and iSTOP together in IDLE -> start.
- iLOOP is sampled only in LOAD at an end condition.
- iRST mid-operation: immediate return to reset values; no oDONE.

Optional Feature:
- Macro SEQ_ARTIC_EN.
- Defined: articulation gap. While in PLAY with dur_cnt==1 and latched dur>=2, oGATE=0, so repeated identical notes are audibly separated. Notes with dur==1 get no gap.
- Undefined: oGATE stays at (half!=0) for the whole note, including LOAD.

Test Plan (TICK_DIV=4):
1. Table {0:(10,2), 1:(0,1), 2:(x,0)}, iLOOP=0, iSTART pulse at cycle 0 -> sequence as follows:
   - cycle 1: LOAD.
   - cycles 2-9: oHALF=10, oGATE=1; oNOTE_STB at cycle 2.
   - cycle 10: LOAD.
   - cycles 11-14: oHALF=0, oGATE=0; oNOTE_STB at cycle 11.
   - cycle 15: LOAD.
   - cycle 16: IDLE, oDONE=1, oBUSY=0.
2. Same table, iLOOP=1 -> after the cycle-15 marker, idx resets to 0 and entry 0 replays (oNOTE_STB at cycle 17, oHALF=10). Runs indefinitely with no oDONE.
3. Test 1 stimulus, iSTOP at cycle 5 -> cycle 6: IDLE, oGATE=0, oHALF=0, oBUSY=0, no oDONE; a later iSTART replays from entry 0.
4. Entry 0 dur=0, iLOOP=1, iSTART -> LOAD, then IDLE with oDONE pulse; no oNOTE_STB, oGATE never high.
5. All 16 entries (i+1,1), no marker, iLOOP=0 -> 16 oNOTE_STB pulses 5 cycles apart, oIDX 0..15, then oDONE; with SEQ_ARTIC_EN, oGATE stays high through each note.
6. Entry 0 (7,3) with SEQ_ARTIC_EN -> oGATE high for 8 cycles then low for 4. iRST asserted mid-note -> all outputs at reset values next cycle.
